ps2_scan_receiver: RTL and testbench

Receives PS/2 keyboard frames on the board's ps2_clk/ps2_data pins and checks start, stop, parity and inter-bit timeout. Queues valid scan-code bytes in a small first-word-fall-through FIFO. Sits on the input side of the lab top level, opposite the seven-segment scan driver: it feeds key make/break codes to the clock/timer controllers in place of switches. Runs entirely in the system `clock` domain and oversamples the slow PS/2 clock.

---
 rtl/ps2_scan_receiver.sv | 151 +++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard frame receiver with a first-word-fall-through scan-code FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd-parity check fails.
module ps2_scan_receiver #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Two-flop synchronizers; bit 0 carries ps2_clk, bit 1 carries ps2_data.
    logic [1:0] pin;
    logic [1:0] sync;
    assign pin = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clock or negedge rst) begin
                if (!rst) begin
                    s1_reg <= 1'b1;
                    s2_reg <= 1'b1;
                end else begin
                    s1_reg <= pin[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync[gi] = s2_reg;
        end
    endgenerate

    logic s3_reg;
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) s3_reg <= 1'b1;
        else      s3_reg <= sync[0];
    end

    logic fall;
    logic bit_s;
    assign fall  = s3_reg & ~sync[0];
    assign bit_s = sync[1];

    // Frame receiver: cnt 0 is idle, 1..8 data bits, 9 parity, 10 stop.
    logic [3:0]    cnt_reg;
    logic [7:0]    shreg_reg;
    logic [TW-1:0] tcnt_reg;
    logic          frame_err_reg;
    logic          frame_ok;
    logic          push;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_reg;
    always_ff @(posedge clock or negedge rst) begin
        if (!rst)                              parity_reg <= 1'b0;
        else if (fall && cnt_reg == 4'd9)      parity_reg <= bit_s;
    end
    always_comb begin
        frame_ok = bit_s & (^{shreg_reg, parity_reg});
    end
`else
    always_comb begin
        frame_ok = bit_s;
    end
`endif

    assign push = fall && (cnt_reg == 4'd10) && frame_ok;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt_reg       <= 4'd0;
            shreg_reg     <= 8'h00;
            tcnt_reg      <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            if (cnt_reg == 4'd0) begin
                tcnt_reg <= '0;
                if (fall && !bit_s) cnt_reg <= 4'd1;
            end else if (fall) begin
                tcnt_reg <= '0;
                if (cnt_reg <= 4'd8) begin
                    shreg_reg <= {bit_s, shreg_reg[7:1]};
                    cnt_reg   <= cnt_reg + 4'd1;
                end else if (cnt_reg == 4'd9) begin
                    cnt_reg <= 4'd10;
                end else begin
                    cnt_reg <= 4'd0;
                    if (!frame_ok) frame_err_reg <= 1'b1;
                end
            end else if (tcnt_reg == TIMEOUT_LAST) begin
                // Stalled frame: abandon the partial byte.
                cnt_reg       <= 4'd0;
                tcnt_reg      <= '0;
                frame_err_reg <= 1'b1;
            end else begin
                tcnt_reg <= tcnt_reg + 1'b1;
            end
        end
    end

    assign frame_err = frame_err_reg;

    // FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wptr_reg;
    logic [AW:0] rptr_reg;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        overflow_reg;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_ok;

    assign empty   = (wptr_reg == rptr_reg);
    assign full    = (wptr_reg[AW] != rptr_reg[AW]) &&
                     (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign pop     = rd && !empty;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (push_ok) mem[wptr_reg[AW-1:0]] <= shreg_reg;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) wptr_reg <= wptr_reg + 1'b1;
            if (pop)     rptr_reg <= rptr_reg + 1'b1;
            if (push && full && !pop) overflow_reg <= 1'b1;
        end
    end

    assign data     = empty ? 8'h00 : mem[rptr_reg[AW-1:0]];
    assign ready    = !empty;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver: queue-based model compared every
// cycle, plus literal spot checks on directed scan-code frames.
module tb_ps2_scan_receiver;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 20;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    ps2_scan_receiver #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .rd(rd),
        .data(data),
        .ready(ready),
        .overflow(overflow),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int err_pulses = 0;

    logic [7:0] model_q[$];
    bit model_ovf = 1'b0;
    bit exp_err = 1'b0;
    bit cmp_en = 1'b0;
    bit err_cmp_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] model_head();
        return (model_q.size() > 0) ? model_q[0] : 8'h00;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (frame_err === 1'b1) err_pulses++;
        if (cmp_en) begin
            check("data", {24'd0, data}, {24'd0, model_head()});
            check("ready", {31'd0, ready}, {31'd0, (model_q.size() > 0)});
            check("overflow", {31'd0, overflow}, {31'd0, model_ovf});
            if (err_cmp_en) check("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic model_push(input logic [7:0] b, input bit pop_same);
        if (pop_same && model_q.size() > 0) void'(model_q.pop_front());
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
    endtask

    // One full PS/2 frame; the model updates two edges after the stop-bit edge E0.
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop, input bit rd_on_push);
        logic [10:0] bits;
        logic        par;
        bit          valid;
        par  = (~^b) ^ flip_par;
        bits = {stop, par, b, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
        valid = stop && ($countones({b, par}) % 2 == 1);
`else
        valid = stop;
`endif
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            if (i == 10) begin
                @(posedge clock);
                @(posedge clock);
                #1 if (rd_on_push) rd = 1'b1;
                @(posedge clock);
                if (valid) model_push(b, rd_on_push);
                else begin
                    if (rd_on_push && model_q.size() > 0) void'(model_q.pop_front());
                    exp_err = 1'b1;
                end
                #1 rd = 1'b0;
                @(posedge clock);
                exp_err = 1'b0;
                repeat (HALF - 3) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clock);
        $display("frame %02h par_flip=%0d stop=%0d rd=%0d valid=%0d depth=%0d", b, flip_par, stop, rd_on_push, valid, model_q.size());
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            ps2_data = (i == 0) ? 1'b0 : i[0];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        $display("partial frame of %0d bits", nbits);
    endtask

    task automatic do_pop();
        @(negedge clock);
        rd = 1'b1;
        @(posedge clock);
        if (model_q.size() > 0) void'(model_q.pop_front());
        #1 rd = 1'b0;
        $display("pop -> depth=%0d", model_q.size());
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 rst = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        exp_err = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        #2 rst = 1'b1;
        $display("reset pulse");
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        @(negedge clock);
        #1 check(name, act, exp);
    endtask

    int base;
    int n;

    initial begin
        repeat (3) @(negedge clock);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        cmp_en = 1'b1;
        #2 rst = 1'b1;
        repeat (10) @(negedge clock);

        // Single byte, then pop.
        base = err_pulses;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        lit("1c_data", {24'd0, data}, 32'h1C);
        lit("1c_ready", {31'd0, ready}, 32'd1);
        check("1c_no_err", err_pulses - base, 0);
        do_pop();
        lit("1c_pop_ready", {31'd0, ready}, 32'd0);
        lit("1c_pop_data", {24'd0, data}, 32'h00);

        // Break code sequence.
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        lit("f0_head", {24'd0, data}, 32'hF0);
        do_pop();
        lit("f0_next", {24'd0, data}, 32'h1C);
        do_pop();
        lit("f0_empty", {31'd0, ready}, 32'd0);

        // Wrong parity bit.
        base = err_pulses;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err_pulses", err_pulses - base, 1);
        lit("par_ready", {31'd0, ready}, 32'd0);
`else
        check("par_err_pulses", err_pulses - base, 0);
        lit("par_data", {24'd0, data}, 32'h1C);
        do_pop();
`endif

        // Bad stop bit.
        base = err_pulses;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check("stop_err_pulses", err_pulses - base, 1);
        lit("stop_ready", {31'd0, ready}, 32'd0);

        // Full FIFO with pop on the same cycle as the ninth push.
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        send_frame(8'h09, 1'b0, 1'b1, 1'b1);
        lit("simul_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            lit("simul_pop", {24'd0, data}, 32'(i + 2));
            do_pop();
        end
        lit("simul_empty", {31'd0, ready}, 32'd0);

        // Overflow on the ninth push.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        lit("ovf_set", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            lit("ovf_pop", {24'd0, data}, 32'(i + 1));
            do_pop();
        end
        lit("ovf_empty", {31'd0, ready}, 32'd0);
        lit("ovf_sticky", {31'd0, overflow}, 32'd1);
        do_reset();
        lit("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Inter-bit timeout.
        err_cmp_en = 1'b0;
        base = err_pulses;
        send_partial(5);
        repeat (TMO + 50) @(negedge clock);
        n = err_pulses - base;
        check("timeout_pulses", n, 1);
        err_cmp_en = 1'b1;
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        lit("tmo_data", {24'd0, data}, 32'h29);
        do_pop();

        // Reset in the middle of a frame.
        send_partial(4);
        do_reset();
        repeat (5) @(negedge clock);
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        lit("rst_mid_data", {24'd0, data}, 32'h29);
        lit("rst_mid_ready", {31'd0, ready}, 32'd1);
        do_pop();
        lit("rst_mid_empty", {31'd0, ready}, 32'd0);

        repeat (5) @(negedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
